// File: rtl/td4_pkg.sv
// Shared encodings, widths and the 4-bit add helper for the TD4 datapath.
package td4_pkg;

  localparam int TD4_W = 4;

  // Source select encodings for the operand mux.
  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_IN   = 2'b10,
    SEL_ZERO = 2'b11
  } sel_e;

  // Bit positions inside the active-low load strobe vector.
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  typedef struct packed {
    logic             carry;
    logic [TD4_W-1:0] result;
  } alu_res_t;

  // Zero-extended add; carry is bit 4 of the 5-bit sum.
  function automatic alu_res_t td4_add(input logic [TD4_W-1:0] a,
                                       input logic [TD4_W-1:0] b);
    logic [TD4_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return '{carry: sum[TD4_W], result: sum[TD4_W-1:0]};
  endfunction

endpackage

// File: rtl/td4_if.sv
// Control/data bundle between the TD4 decoder side and the datapath.
interface td4_if;
  import td4_pkg::*;

  logic             en;
  logic [1:0]       select;
  logic [3:0]       load;
  logic [TD4_W-1:0] imm;
  logic [TD4_W-1:0] in_port;
  logic [TD4_W-1:0] out_port;
  logic [TD4_W-1:0] pc;
  logic             cflg;
  logic [TD4_W-1:0] reg_a;
  logic [TD4_W-1:0] reg_b;

  // Decoder / stimulus side: drives controls, observes register state.
  modport master (
    output en, select, load, imm, in_port,
    input  out_port, pc, cflg, reg_a, reg_b
  );

  // Datapath side.
  modport slave (
    input  en, select, load, imm, in_port,
    output out_port, pc, cflg, reg_a, reg_b
  );

endinterface

// File: rtl/td4_reg4.sv
// 4-bit register with async active-high reset, step enable and active-low load.
module td4_reg4
  import td4_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_n,
  input  logic [TD4_W-1:0] d,
  output logic [TD4_W-1:0] q
);

  logic [TD4_W-1:0] data_d;
  logic [TD4_W-1:0] data_q;

  // Next value: capture d only on an enabled step with the strobe low.
  always_comb begin
    // NOTE: default first so every path assigns data_d and no latch is inferred.
    data_d = data_q;
    if (en && !load_n) begin
      data_d = d;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset in the sensitivity list makes it asynchronous; release timing is the caller's job.
    if (rst) begin
      data_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values (read-modify-write safe).
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/td4_datapath.sv
// TD4 datapath: operand mux, 4-bit adder, A/B/OUT registers, PC and carry flag.
module td4_datapath
  import td4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  td4_if.slave bus
);

  logic [TD4_W-1:0] mux_out;
  alu_res_t         alu;
  logic [TD4_W-1:0] a_val;
  logic [TD4_W-1:0] b_val;
  logic [TD4_W-1:0] out_val;

  logic [TD4_W-1:0] pc_d;
  logic [TD4_W-1:0] pc_q;
  logic             cflg_d;
  logic             cflg_q;

  // Operand mux; reads register outputs so A+imm uses the pre-edge A.
  always_comb begin
    mux_out = '0;
    unique case (sel_e'(bus.select))
      SEL_A:    mux_out = a_val;
      SEL_B:    mux_out = b_val;
      SEL_IN:   mux_out = bus.in_port;
      SEL_ZERO: mux_out = '0;
      default:  mux_out = '0;
    endcase
  end

  assign alu = td4_add(mux_out, bus.imm);

  td4_reg4 u_reg_a (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .load_n (bus.load[LD_A]),
    .d      (alu.result),
    .q      (a_val)
  );

  td4_reg4 u_reg_b (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .load_n (bus.load[LD_B]),
    .d      (alu.result),
    .q      (b_val)
  );

  td4_reg4 u_reg_out (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .load_n (bus.load[LD_OUT]),
    .d      (alu.result),
    .q      (out_val)
  );

  // PC jumps to result when its strobe is low, otherwise increments with wrap;
  // carry is refreshed on every enabled step regardless of the strobes.
  always_comb begin
    pc_d   = pc_q;
    cflg_d = cflg_q;
    if (bus.en) begin
      cflg_d = alu.carry;
      if (!bus.load[LD_PC]) begin
        pc_d = alu.result;
      end else begin
        pc_d = pc_q + TD4_W'(1);
      end
    end
  end

  // PC and carry flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      cflg_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cflg_q <= cflg_d;
    end
  end

  assign bus.reg_a    = a_val;
  assign bus.reg_b    = b_val;
  assign bus.out_port = out_val;
  assign bus.pc       = pc_q;
  assign bus.cflg     = cflg_q;

endmodule

// File: doc/td4_datapath.md
TD4_DATAPATH -- requirements
Module: td4_datapath

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 en  input  1  step enable; state updates only when high.
REQ-004 select  input  2  source select: 00=A, 01=B, 10=in_port, 11=zero.
REQ-005 load  input  4  active-low register load strobes: bit0=A, bit1=B, bit2=OUT, bit3=PC.
REQ-006 imm  input  4  immediate operand from current instruction.
REQ-007 in_port  input  4  external input port.
REQ-008 out_port  output  4  OUT register contents.
REQ-009 pc  output  4  program counter; drives program ROM address.
REQ-010 cflg  output  1  registered carry flag; feeds the decoder.
REQ-011 reg_a, reg_b  output  4 each  A and B register contents, for debug and test.

Function
REQ-012 Mux output: A, B, in_port or 4'h0 per select; purely combinational.
REQ-013 Sum: 5-bit result of mux output plus imm, zero-extended; result = sum[3:0], carry = sum[4].
REQ-014 On a rising edge with en=1, each of A, B and OUT with its load bit at 0 loads result; otherwise it holds.
REQ-015 On a rising edge with en=1, PC loads result if load[3]=0; otherwise PC loads PC+1 modulo 16 (15 -> 0).
REQ-016 On a rising edge with en=1, cflg loads carry on every edge, independent of load.
REQ-017 When en=0, A, B, OUT, PC and cflg hold.
REQ-018 Multiple load bits low in the same cycle: every selected register loads the same result (defined, not an error).
REQ-019 Load latency is one cycle: an updated register value is visible on outputs after the capturing edge.
REQ-020 Read-modify-write (for example ADD A,Im) uses the pre-edge value of A; there is no combinational loop.
REQ-021 in_port is sampled only through the mux, with no synchronizer in this block.
REQ-022 All outputs are register outputs with no combinational path from inputs.

Reset
REQ-023 While rst=1: A, B, OUT and PC = 4'h0, and cflg = 0, regardless of clk and en.
REQ-024 Reset asserted mid-operation clears state immediately; the first enabled edge after release executes from PC=0.
REQ-025 Release of rst is synchronous to clk by upstream convention; this block adds no reset synchronizer.

Structure
REQ-026 Shared package td4_pkg holds:
- select encodings SEL_A, SEL_B, SEL_IN, SEL_ZERO;
- load bit indices LD_A, LD_B, LD_OUT, LD_PC;
- register width constant TD4_W = 4.
REQ-027 One sub-module td4_reg4: 4-bit register with async active-high reset, enable and active-low load; instantiated for A, B and OUT.
REQ-028 PC and cflg are implemented in td4_datapath itself; the adder is inline.

Verification
REQ-029 Reset then MOV A,5 (select=11, load=1110, imm=5, en=1) -> A=5, pc=1, cflg=0.
REQ-030 With A=5, ADD A,12 (select=00, load=1110, imm=12) -> A=1, cflg=1, pc=2; then NOP-like ADD A,0 -> A=1, cflg=0.
REQ-031 IN B with in_port=9 (select=10, load=1101, imm=0) -> B=9, A unchanged; OUT B (select=01, load=1011, imm=0) -> out_port=9.
REQ-032 JMP 3 (select=11, load=0111, imm=3) -> pc=3 and cflg=0; separately, 16 NOP-style cycles (load=1111) from pc=0 -> pc wraps to 0.
REQ-033 en=0 for 3 cycles with load=0000 -> no register or flag changes; then en=1 with load=0000, select=11, imm=7 -> A=B=OUT=PC=7.
REQ-034 Assert rst asynchronously between edges with A=5 and pc=6 -> all outputs 0 before the next edge; after release, the first edge gives pc=1.
